// File: rtl/cache_bank_mp_if.sv
// Bus bundle for the multi-read-port cache data bank: one write port,
// NUM_RD packed read ports, the flush request and the busy indication.
interface cache_bank_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RD     = 4
);
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_valid;
    logic [NUM_RD-1:0]            rd_hit;
    logic                         flush_req;
    logic                         busy;

    // Requester side: cache controller and lookup units.
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, flush_req,
        input  rd_data, rd_valid, rd_hit, busy
    );

    // Bank side.
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, flush_req,
        output rd_data, rd_valid, rd_hit, busy
    );
endinterface

// File: rtl/cache_bank_mp.sv
// Multi-read-port cache data bank. The data array has no reset; a sweep
// engine zeroes one line per cycle after reset or flush while busy is high.
// Each read port has a 1-cycle registered read with write-first bypass.
module cache_bank_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RD     = 4
) (
    input  logic          clk,
    input  logic          reset,
    cache_bank_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_LINE = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} stateType;

    stateType              state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [DEPTH-1:0]      validBits;
    logic                  flushDelay;
    logic                  busyReg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  isIdle;
    logic                  wrAccept;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memData;

    assign isIdle   = (state == IDLE);
    assign wrAccept = isIdle && bus.wr_en && !bus.flush_req;
    assign bus.busy = busyReg;

    // Single array write port: sweep zeroes during INIT, otherwise accepted writes.
    always_comb begin
        memWe   = 1'b0;
        memAddr = bus.wr_addr;
        memData = bus.wr_data;
        if (!isIdle) begin
            memWe   = !reset;
            memAddr = cnt[ADDR_WIDTH-1:0];
            memData = '0;
        end else if (wrAccept) begin
            memWe = 1'b1;
        end
    end

    // Control FSM: sweep counter, valid bits and busy.
    // A flush spends one extra cycle before counting so its sweep is DEPTH+1
    // cycles long; the flush edge itself still serves reads from old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= '0;
            validBits  <= '0;
            busyReg    <= 1'b1;
            flushDelay <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (flushDelay) begin
                        flushDelay <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_LINE) begin
                            state   <= IDLE;
                            busyReg <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    if (bus.flush_req) begin
                        state      <= INIT;
                        cnt        <= '0;
                        validBits  <= '0;
                        busyReg    <= 1'b1;
                        flushDelay <= 1'b1;
                    end else if (bus.wr_en) begin
                        validBits[bus.wr_addr] <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Data array write, no reset so it can map to SRAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : gRead
            logic [ADDR_WIDTH-1:0] addr;
            logic                  bypass;
            logic [DATA_WIDTH-1:0] dataReg;
            logic                  validReg;
            logic                  hitReg;

            assign addr   = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign bypass = wrAccept && (bus.wr_addr == addr);

            // Registered read with write-first forwarding; data/hit hold when idle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dataReg  <= '0;
                    validReg <= 1'b0;
                    hitReg   <= 1'b0;
                end else if (isIdle && bus.rd_en[gi]) begin
                    validReg <= 1'b1;
                    if (bypass) begin
                        dataReg <= bus.wr_data;
                        hitReg  <= 1'b1;
                    end else begin
                        dataReg <= mem[addr];
                        hitReg  <= validBits[addr];
                    end
                end else begin
                    validReg <= 1'b0;
                end
            end

            assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = dataReg;
            assign bus.rd_valid[gi] = validReg;
            assign bus.rd_hit[gi]   = hitReg;
        end
    endgenerate
endmodule
